// File: rtl/resonator_dds_deadlock_watchdog.sv
// ---------------------------------------------------------------------------
// resonator_dds_deadlock_watchdog
//
// Purpose:
//   Watchdog over the resonator_dds AXIS deadlock monitor.
//   - Times how long the per-stream block flags stay asserted.
//   - Declares a deadlock after a programmable threshold.
//   - Latches which streams were blocked and raises a sticky interrupt.
//   - Can optionally sequence core recovery: halt, drain wait, then a
//     one-cycle restart pulse.
//
// Optional feature macro:
//   RESONATOR_DDS_WATCHDOG_EVCNT_EN
//     defined   : deadlock_events counts DEADLOCK entries. It saturates and
//                 is cleared only by reset_n.
//     undefined : deadlock_events is tied to zero.
//
// Ports:
//   clock, reset_n    clock and asynchronous active-low reset
//   enable            watchdog enable (level)
//   threshold         blocked cycles needed to declare a deadlock (0 acts as 1)
//   auto_recover      move from DEADLOCK to RECOVER automatically
//   clear             acknowledge pulse: clears deadlock_irq/block_mask and
//                     releases DEADLOCK
//   axis_block_sigs   per-stream blocked flags
//   block_mask        block flags captured on DEADLOCK entry
//   deadlock_irq      sticky deadlock flag
//   core_halt         high throughout RECOVER
//   core_restart      one-cycle pulse on the last RECOVER cycle
//   state             0 IDLE, 1 SUSPECT, 2 DEADLOCK, 3 RECOVER
//   stall_count       consecutive blocked cycles (saturating)
//   deadlock_events   DEADLOCK entry count (zero unless the macro is defined)
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module resonator_dds_deadlock_watchdog #(
    parameter int NUM_AXIS     = 2,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CNT_W-1:0]    threshold,
    input  logic                auto_recover,
    input  logic                clear,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    output logic [NUM_AXIS-1:0] block_mask,
    output logic                deadlock_irq,
    output logic                core_halt,
    output logic                core_restart,
    output logic [1:0]          state,
    output logic [CNT_W-1:0]    stall_count,
    output logic [15:0]         deadlock_events
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SUSPECT  = 2'd1;
    localparam logic [1:0] ST_DEADLOCK = 2'd2;
    localparam logic [1:0] ST_RECOVER  = 2'd3;

    localparam int             DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W:0] CNT_ONE_W  = {{CNT_W{1'b0}}, 1'b1};

    logic [1:0]          state_r;
    logic [1:0]          state_s;
    logic [CNT_W-1:0]    stall_r;
    logic [CNT_W-1:0]    stall_s;
    logic [DW-1:0]       drain_r;
    logic [DW-1:0]       drain_s;
    logic [NUM_AXIS-1:0] mask_r;
    logic [NUM_AXIS-1:0] mask_s;
    logic                irq_r;
    logic                irq_s;
    logic                halt_r;
    logic                restart_r;
    logic                restart_s;
    logic                blk_s;
    logic [CNT_W-1:0]    thr_eff_s;
    logic [CNT_W-1:0]    stall_inc_s;
    logic                reach_s;
    logic                entry_s;

    // Saturating increment of the stall counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Decode the block flags and the effective threshold.
    always_comb begin
        blk_s       = |axis_block_sigs;
        thr_eff_s   = (threshold == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : threshold;
        stall_inc_s = sat_inc(stall_r);
        // Compare the unsaturated count one bit wider, so an all-ones
        // threshold is still reachable.
        reach_s     = (({1'b0, stall_r} + CNT_ONE_W) >= {1'b0, thr_eff_s});
    end

    // Next-state logic for the state, stall counter, drain counter and restart pulse.
    always_comb begin
        state_s   = state_r;
        stall_s   = stall_r;
        drain_s   = drain_r;
        restart_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_SUSPECT: begin
                if (enable && blk_s) begin
                    stall_s = stall_inc_s;
                    if (reach_s) begin
                        state_s = ST_DEADLOCK;
                    end else begin
                        state_s = ST_SUSPECT;
                    end
                end else begin
                    stall_s = {CNT_W{1'b0}};
                    state_s = ST_IDLE;
                end
            end
            ST_DEADLOCK: begin
                if (clear) begin
                    state_s = ST_IDLE;
                    stall_s = {CNT_W{1'b0}};
                end else if (auto_recover) begin
                    state_s   = ST_RECOVER;
                    drain_s   = {DW{1'b0}};
                    restart_s = (DRAIN_LAST == {DW{1'b0}});
                end else begin
                    state_s = ST_DEADLOCK;
                end
            end
            ST_RECOVER: begin
                if (drain_r == DRAIN_LAST) begin
                    state_s = ST_IDLE;
                    stall_s = {CNT_W{1'b0}};
                    drain_s = {DW{1'b0}};
                end else begin
                    drain_s   = drain_r + {{(DW-1){1'b0}}, 1'b1};
                    restart_s = (drain_s == DRAIN_LAST);
                end
            end
            default: begin
                state_s = ST_IDLE;
                stall_s = {CNT_W{1'b0}};
                drain_s = {DW{1'b0}};
            end
        endcase
    end

    // Update the irq and mask. A DEADLOCK entry wins over a simultaneous clear.
    always_comb begin
        entry_s = (state_r != ST_DEADLOCK) && (state_s == ST_DEADLOCK);
        if (entry_s) begin
            irq_s  = 1'b1;
            mask_s = axis_block_sigs;
        end else if (clear) begin
            irq_s  = 1'b0;
            mask_s = {NUM_AXIS{1'b0}};
        end else begin
            irq_s  = irq_r;
            mask_s = mask_r;
        end
    end

    // Main state and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            stall_r   <= {CNT_W{1'b0}};
            drain_r   <= {DW{1'b0}};
            mask_r    <= {NUM_AXIS{1'b0}};
            irq_r     <= 1'b0;
            halt_r    <= 1'b0;
            restart_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            stall_r   <= stall_s;
            drain_r   <= drain_s;
            mask_r    <= mask_s;
            irq_r     <= irq_s;
            halt_r    <= (state_s == ST_RECOVER);
            restart_r <= restart_s;
        end
    end

`ifdef RESONATOR_DDS_WATCHDOG_EVCNT_EN
    logic [15:0] events_r;

    // Saturating count of DEADLOCK entries. Only reset_n clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            events_r <= 16'h0000;
        end else if (entry_s && (events_r != 16'hFFFF)) begin
            events_r <= events_r + 16'h0001;
        end else begin
            events_r <= events_r;
        end
    end

    assign deadlock_events = events_r;
`else
    assign deadlock_events = 16'h0000;
`endif

    assign state        = state_r;
    assign stall_count  = stall_r;
    assign block_mask   = mask_r;
    assign deadlock_irq = irq_r;
    assign core_halt    = halt_r;
    assign core_restart = restart_r;

endmodule

// File: tb/tb_resonator_dds_deadlock_watchdog.sv
// ---------------------------------------------------------------------------
// tb_resonator_dds_deadlock_watchdog
//
// Purpose:
//   Directed testbench for resonator_dds_deadlock_watchdog, using the
//   default parameters: NUM_AXIS=2, CNT_W=16, DRAIN_CYCLES=8.
//
// Method:
//   - Inputs are driven 1 ns after each rising edge.
//   - Outputs are checked 1 ns after each rising edge.
//   - Expected values are computed by hand.
// ---------------------------------------------------------------------------
module tb_resonator_dds_deadlock_watchdog;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [15:0] threshold;
    logic        auto_recover;
    logic        clear;
    logic [1:0]  axis_block_sigs;
    logic [1:0]  block_mask;
    logic        deadlock_irq;
    logic        core_halt;
    logic        core_restart;
    logic [1:0]  state;
    logic [15:0] stall_count;
    logic [15:0] deadlock_events;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ev = 0;

    resonator_dds_deadlock_watchdog #(
        .NUM_AXIS(2),
        .CNT_W(16),
        .DRAIN_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .threshold(threshold),
        .auto_recover(auto_recover),
        .clear(clear),
        .axis_block_sigs(axis_block_sigs),
        .block_mask(block_mask),
        .deadlock_irq(deadlock_irq),
        .core_halt(core_halt),
        .core_restart(core_restart),
        .state(state),
        .stall_count(stall_count),
        .deadlock_events(deadlock_events)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count one comparison and report it if it mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected event count: zero unless the counter is built.
    function automatic logic [31:0] ev_exp(input int n);
`ifdef RESONATOR_DDS_WATCHDOG_EVCNT_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        reset_n         = 1'b0;
        enable          = 1'b0;
        threshold       = 16'd5;
        auto_recover    = 1'b0;
        clear           = 1'b0;
        axis_block_sigs = 2'b00;
        tick();
        tick();

        // Reset state.
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_irq", 32'(deadlock_irq), 32'd0);
        check_eq("rst_mask", 32'(block_mask), 32'd0);
        check_eq("rst_halt", 32'(core_halt), 32'd0);
        check_eq("rst_stall", 32'(stall_count), 32'd0);
        check_eq("rst_events", 32'(deadlock_events), 32'd0);
        reset_n = 1'b1;
        tick();

        // Test 1: threshold 5, 2'b01 held -> DEADLOCK at edge 5.
        enable          = 1'b1;
        axis_block_sigs = 2'b01;
        tick();
        check_eq("t1_e1_state", 32'(state), 32'd1);
        check_eq("t1_e1_stall", 32'(stall_count), 32'd1);
        tick();
        tick();
        tick();
        check_eq("t1_e4_state", 32'(state), 32'd1);
        check_eq("t1_e4_irq", 32'(deadlock_irq), 32'd0);
        tick();
        exp_ev = 1;
        check_eq("t1_e5_state", 32'(state), 32'd2);
        check_eq("t1_e5_irq", 32'(deadlock_irq), 32'd1);
        check_eq("t1_e5_mask", 32'(block_mask), 32'd1);
        check_eq("t1_e5_stall", 32'(stall_count), 32'd5);
        check_eq("t1_events", 32'(deadlock_events), ev_exp(exp_ev));

        // DEADLOCK is sticky once the block flags drop.
        axis_block_sigs = 2'b00;
        tick();
        check_eq("t1_sticky_state", 32'(state), 32'd2);
        check_eq("t1_sticky_stall", 32'(stall_count), 32'd5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("t1_clr_state", 32'(state), 32'd0);
        check_eq("t1_clr_irq", 32'(deadlock_irq), 32'd0);
        check_eq("t1_clr_mask", 32'(block_mask), 32'd0);
        check_eq("t1_clr_stall", 32'(stall_count), 32'd0);

        // Test 2: 3 blocked cycles, then released -> back to IDLE.
        axis_block_sigs = 2'b10;
        tick();
        tick();
        tick();
        check_eq("t2_state", 32'(state), 32'd1);
        check_eq("t2_stall", 32'(stall_count), 32'd3);
        axis_block_sigs = 2'b00;
        tick();
        check_eq("t2_idle", 32'(state), 32'd0);
        check_eq("t2_stall0", 32'(stall_count), 32'd0);
        check_eq("t2_irq", 32'(deadlock_irq), 32'd0);

        // Test 3: automatic recovery after a deadlock.
        axis_block_sigs = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        exp_ev = 2;
        check_eq("t3_dl", 32'(state), 32'd2);
        axis_block_sigs = 2'b00;
        auto_recover    = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check_eq($sformatf("t3_halt_c%0d", c), 32'(core_halt), 32'd1);
            check_eq($sformatf("t3_rst_c%0d", c), 32'(core_restart), (c == 8) ? 32'd1 : 32'd0);
            check_eq($sformatf("t3_state_c%0d", c), 32'(state), 32'd3);
        end
        tick();
        check_eq("t3_end_state", 32'(state), 32'd0);
        check_eq("t3_end_halt", 32'(core_halt), 32'd0);
        check_eq("t3_end_restart", 32'(core_restart), 32'd0);
        check_eq("t3_end_stall", 32'(stall_count), 32'd0);
        check_eq("t3_end_irq", 32'(deadlock_irq), 32'd1);
        check_eq("t3_end_mask", 32'(block_mask), 32'd1);
        auto_recover = 1'b0;
        clear        = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("t3_clr_irq", 32'(deadlock_irq), 32'd0);

        // Test 4: clear and auto_recover together with blk=1 -> IDLE.
        // Counting restarts on the following edge.
        axis_block_sigs = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        exp_ev = 3;
        check_eq("t4_dl", 32'(state), 32'd2);
        check_eq("t4_events", 32'(deadlock_events), ev_exp(exp_ev));
        clear        = 1'b1;
        auto_recover = 1'b1;
        tick();
        clear        = 1'b0;
        auto_recover = 1'b0;
        check_eq("t4_state", 32'(state), 32'd0);
        check_eq("t4_irq", 32'(deadlock_irq), 32'd0);
        check_eq("t4_mask", 32'(block_mask), 32'd0);
        check_eq("t4_halt", 32'(core_halt), 32'd0);
        check_eq("t4_stall", 32'(stall_count), 32'd0);
        tick();
        check_eq("t4_recount_state", 32'(state), 32'd1);
        check_eq("t4_recount_stall", 32'(stall_count), 32'd1);
        check_eq("t4_recount_halt", 32'(core_halt), 32'd0);

        // enable=0 forces SUSPECT back to IDLE.
        enable = 1'b0;
        tick();
        check_eq("en0_state", 32'(state), 32'd0);
        check_eq("en0_stall", 32'(stall_count), 32'd0);
        axis_block_sigs = 2'b00;
        enable          = 1'b1;
        tick();

        // Test 5: threshold 0 -> DEADLOCK straight from IDLE.
        threshold       = 16'd0;
        axis_block_sigs = 2'b10;
        tick();
        exp_ev = 4;
        check_eq("t5_state", 32'(state), 32'd2);
        check_eq("t5_stall", 32'(stall_count), 32'd1);
        check_eq("t5_mask", 32'(block_mask), 32'd2);
        check_eq("t5_irq", 32'(deadlock_irq), 32'd1);
        axis_block_sigs = 2'b00;
        clear           = 1'b1;
        tick();
        check_eq("t5_clr_state", 32'(state), 32'd0);

        // A DEADLOCK entry wins over a simultaneous clear.
        axis_block_sigs = 2'b01;
        tick();
        exp_ev = 5;
        check_eq("t5_win_state", 32'(state), 32'd2);
        check_eq("t5_win_irq", 32'(deadlock_irq), 32'd1);
        check_eq("t5_win_mask", 32'(block_mask), 32'd1);
        axis_block_sigs = 2'b00;
        tick();
        clear = 1'b0;
        check_eq("t5_win_clr", 32'(deadlock_irq), 32'd0);
        check_eq("t5_events", 32'(deadlock_events), ev_exp(exp_ev));

        // Reset asserted during RECOVER: outputs drop at once, no restart pulse.
        axis_block_sigs = 2'b01;
        tick();
        exp_ev = 6;
        axis_block_sigs = 2'b00;
        auto_recover    = 1'b1;
        tick();
        tick();
        tick();
        check_eq("t5r_halt_pre", 32'(core_halt), 32'd1);
        check_eq("t5r_events_pre", 32'(deadlock_events), ev_exp(exp_ev));
        reset_n = 1'b0;
        #1;
        check_eq("t5r_halt", 32'(core_halt), 32'd0);
        check_eq("t5r_state", 32'(state), 32'd0);
        check_eq("t5r_irq", 32'(deadlock_irq), 32'd0);
        check_eq("t5r_mask", 32'(block_mask), 32'd0);
        check_eq("t5r_events", 32'(deadlock_events), 32'd0);
        exp_ev = 0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("t5r_norestart_%0d", i), 32'(core_restart), 32'd0);
            check_eq($sformatf("t5r_nohalt_%0d", i), 32'(core_halt), 32'd0);
        end
        check_eq("t5r_events_post", 32'(deadlock_events), ev_exp(exp_ev));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
